// File: rtl/tdm_pkg.sv
// tdm_pkg: shared frame geometry and FSM state type for the 4-slot TDM demultiplexer
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot index counter; clr -> 0, load1 -> 1, inc -> +1 wrapping at NUM_SLOTS-1
// Ports: clk, rst (async, active high), inc/load1/clr controls (clr wins, then load1), slot = current index
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot
);
  logic [SLOT_W-1:0] slot_q, slot_d;
  always_comb
    slot_d = clr   ? '0 :
             load1 ? SLOT_W'(1) :
             inc   ? (slot_q == SLOT_W'(NUM_SLOTS - 1) ? '0 : slot_q + 1'b1) :
                     slot_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) slot_q <= '0;
    else slot_q <= slot_d;
  assign slot = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: splits a sync-framed 4-slot TDM sample stream into four registered channel outputs
// Ports: clk, rst (async, active high); din/en/sync sample stream with strobe and slot-0 marker;
//        err_clr clears sync_err; out0..out3 last complete frame; frame_valid one-cycle new-frame pulse;
//        slot = index expected for next sample; locked = FSM in LOCKED; sync_err sticky framing error
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              en,
  input  logic              sync,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] shad_q [3];
  logic [WIDTH-1:0] shad_d [3];
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic fv_q, fv_d, err_q, err_d;
  logic err_set, inc, load1, clr;
  tdm_slot_ctr u_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .load1(load1),
    .clr  (clr),
    .slot (slot)
  );
  // The slot-3 sample goes straight to out3, so only slots 0..2 need a shadow.
  // A partial frame is discarded implicitly: outputs load only on slot-3 completion,
  // and any restart overwrites shadow 0 before the next completion can occur.
  always_comb begin
    state_d = state_q;
    shad_d  = shad_q;
    out_d   = out_q;
    fv_d    = 1'b0;
    err_set = 1'b0;
    inc     = 1'b0;
    load1   = 1'b0;
    clr     = 1'b0;
    if (en) begin
      if (state_q == HUNT) begin
        if (sync) begin
          shad_d[0] = din;
          load1     = 1'b1;
          state_d   = LOCKED;
        end
      end else if (sync) begin
        err_set   = slot != '0;
        shad_d[0] = din;
        load1     = 1'b1;
      end else if (slot == '0) begin
        err_set = 1'b1;
        clr     = 1'b1;
        state_d = HUNT;
      end else begin
        inc = 1'b1;
        for (int i = 1; i < 3; i++) if (slot == SLOT_W'(i)) shad_d[i] = din;
        if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
          out_d = '{shad_q[0], shad_q[1], shad_q[2], din};
          fv_d  = 1'b1;
        end
      end
    end
    err_d = err_set | (err_q & ~err_clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= HUNT;
      shad_q  <= '{default: '0};
      out_q   <= '{default: '0};
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shad_q  <= shad_d;
      out_q   <= out_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign frame_valid = fv_q;
  assign locked      = state_q == LOCKED;
  assign sync_err    = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: vector table, corner-case sequences and random stream checked against a frame-level model
module tb_tdm_demux4;
  localparam int W = 4;
  logic clk = 1'b0, rst, en, sync, err_clr;
  logic [W-1:0] din, out0, out1, out2, out3;
  logic frame_valid, locked, sync_err;
  logic [1:0] slot;
  int n_chk = 0, n_fail = 0;
  logic m_locked, m_fv, m_err;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_out [4];
  typedef struct {
    int en, sync, din, clr, e_fv, e_slot, e_lk, e_err, e_out;
  } vec_t;
  vec_t tbl [13];
  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync), .err_clr(err_clr),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .frame_valid(frame_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // Frame-level model: the partial frame is a queue; its length is the expected slot.
  task automatic model(input logic e, input logic s, input logic [W-1:0] d, input logic c);
    logic new_err;
    new_err = 1'b0;
    m_fv = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin m_q = {d}; m_locked = 1'b1; end
      end else if (s) begin
        new_err = m_q.size() != 0;
        m_q = {d};
      end else if (m_q.size() == 0) begin
        new_err = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
    m_err = new_err | (m_err & ~c);
  endtask
  task automatic check_model();
    chk("out0", 32'(out0), 32'(m_out[0]));
    chk("out1", 32'(out1), 32'(m_out[1]));
    chk("out2", 32'(out2), 32'(m_out[2]));
    chk("out3", 32'(out3), 32'(m_out[3]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("slot", 32'(slot), m_q.size());
    chk("locked", 32'(locked), 32'(m_locked));
    chk("sync_err", 32'(sync_err), 32'(m_err));
  endtask
  task automatic step(input logic e, input logic s, input logic [W-1:0] d, input logic c);
    en = e; sync = s; din = d; err_clr = c;
    @(posedge clk);
    model(e, s, d, c);
    #1;
    check_model();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_locked = 1'b0; m_fv = 1'b0; m_err = 1'b0; m_q.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    chk("rst_outs", 32'({out0, out1, out2, out3}), 32'h0);
    chk("rst_flags", 32'({frame_valid, locked, sync_err, slot}), 32'h0);
    check_model();
    rst = 1'b0;
  endtask
  initial begin
    en = 1'b0; sync = 1'b0; din = '0; err_clr = 1'b0;
    tbl[0]  = '{1, 1, 1, 0, 0, 1, 1, 0, 'h0000};
    tbl[1]  = '{1, 0, 0, 0, 0, 2, 1, 0, 'h0000};
    tbl[2]  = '{1, 0, 1, 0, 0, 3, 1, 0, 'h0000};
    tbl[3]  = '{1, 0, 1, 0, 1, 0, 1, 0, 'h1011};
    tbl[4]  = '{1, 1, 0, 0, 0, 1, 1, 0, 'h1011};
    tbl[5]  = '{1, 0, 1, 0, 0, 2, 1, 0, 'h1011};
    tbl[6]  = '{1, 0, 0, 0, 0, 3, 1, 0, 'h1011};
    tbl[7]  = '{1, 0, 0, 0, 1, 0, 1, 0, 'h0100};
    tbl[8]  = '{1, 1, 1, 0, 0, 1, 1, 0, 'h0100};
    tbl[9]  = '{1, 0, 1, 0, 0, 2, 1, 0, 'h0100};
    tbl[10] = '{1, 0, 1, 0, 0, 3, 1, 0, 'h0100};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 1, 0, 'h1110};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 1, 0, 'h1110};
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].en[0], tbl[k].sync[0], tbl[k].din[W-1:0], tbl[k].clr[0]);
      chk($sformatf("tbl%0d_outs", k), 32'({out0, out1, out2, out3}), tbl[k].e_out);
      chk($sformatf("tbl%0d_flags", k), 32'({frame_valid, slot, locked, sync_err}),
          32'({tbl[k].e_fv[0], tbl[k].e_slot[1:0], tbl[k].e_lk[0], tbl[k].e_err[0]}));
    end
    // en toggling through frame 1,1,0,1: slot frozen on idle cycles
    step(1, 1, 1, 0); step(0, 0, 0, 0);
    chk("freeze_slot", 32'(slot), 1);
    step(1, 0, 1, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("toggle_fv", 32'(frame_valid), 1);
    chk("toggle_outs", 32'({out0, out1, out2, out3}), 32'h1101);
    step(0, 0, 0, 0);
    chk("toggle_fv_drop", 32'(frame_valid), 0);
    // early sync at slot 2
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 0, 0);
    chk("early_err", 32'({sync_err, slot, locked}), 32'({1'b1, 2'd1, 1'b1}));
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);
    chk("early_outs", 32'({out0, out1, out2, out3, frame_valid}), 32'({16'h0001, 1'b1}));
    step(0, 0, 0, 1);
    chk("err_clr", 32'(sync_err), 0);
    // missing sync at slot 0; clear in same cycle must lose to the new error
    step(1, 0, 5, 1);
    chk("lost_lock", 32'({sync_err, locked}), 32'(2'b10));
    step(1, 0, 7, 0); step(1, 0, 3, 0);
    chk("hold_outs", 32'({out0, out1, out2, out3}), 32'h0001);
    step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 1);
    chk("relock_outs", 32'({out0, out1, out2, out3}), 32'h1000);
    // reset mid-frame
    step(1, 1, 1, 0); step(1, 0, 1, 0);
    do_reset();
    step(1, 0, 1, 0); step(1, 0, 1, 0);
    chk("post_rst_idle", 32'({frame_valid, locked}), 0);
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    chk("post_rst_frame", 32'({out0, out1, out2, out3, frame_valid}), 32'({16'h1111, 1'b1}));
    // random stream, mostly well-framed with occasional faults and resets
    for (int n = 0; n < 2000; n++) begin
      logic e, s;
      if ($urandom_range(0, 299) == 0) do_reset();
      e = $urandom_range(0, 3) != 0;
      s = (m_q.size() == 0 && $urandom_range(0, 7) != 0) || $urandom_range(0, 15) == 0;
      step(e, s, W'($urandom), $urandom_range(0, 9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
